// File: rtl/clock_set_ctrl.sv
// Time-of-day sequencing controller: 1 Hz advance strobe plus a button-driven set mode.
// Optional idle abort of set mode is enabled by defining CLOCK_SET_TIMEOUT_EN.
module clock_set_ctrl #(
    parameter int unsigned TICK_DIV  = 50000000,
    parameter int unsigned BLINK_DIV = 12500000,
    parameter int unsigned TIMEOUT_S = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    output logic       sec_tick,
    output logic       load,
    output logic [4:0] ld_hour,
    output logic [5:0] ld_min,
    output logic [5:0] ld_sec,
    output logic [1:0] field_sel,
    output logic       blink
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned BW = $clog2(BLINK_DIV + 1);

    if (TICK_DIV < 2) begin : g_chk_tick
        $error("TICK_DIV must be at least 2");
    end
    if (BLINK_DIV < 1) begin : g_chk_blink
        $error("BLINK_DIV must be at least 1");
    end
    if (TIMEOUT_S < 1) begin : g_chk_timeout
        $error("TIMEOUT_S must be at least 1");
    end

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } state_t;

    state_t          state;
    logic [2:0]      meta;
    logic [2:0]      sync;
    logic [2:0]      hist;
    logic [2:0]      press;
    logic            mode_p;
    logic            inc_p;
    logic            adj_p;
    logic            timeout_hit;
    logic [PW-1:0]   pre_cnt;
    logic [BW-1:0]   blink_cnt;

    // Button order in the vectors: {dec, inc, mode}
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            sync <= '0;
            hist <= '0;
        end else begin
            meta <= {btn_dec, btn_inc, btn_mode};
            sync <= meta;
            hist <= sync;
        end
    end

    assign press  = sync & ~hist;
    assign mode_p = press[0];
    assign inc_p  = press[1] & ~press[2];
    assign adj_p  = press[1] ^ press[2];

    assign field_sel = state;

    // Wrapping +/-1 on a field whose legal range is 0..top
    function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] top,
                                             input logic up);
        if (up) begin
            return (v == top) ? 6'd0 : 6'(v + 6'd1);
        end
        return (v == 6'd0) ? top : 6'(v - 6'd1);
    endfunction

`ifdef CLOCK_SET_TIMEOUT_EN
    localparam int unsigned SW = $clog2(TIMEOUT_S + 1);

    logic [PW-1:0] idle_cyc;
    logic [SW-1:0] idle_sec;

    // Idle seconds in set mode; any press restarts the count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cyc <= '0;
            idle_sec <= '0;
        end else if (state == RUN || (|press)) begin
            idle_cyc <= '0;
            idle_sec <= '0;
        end else if (idle_cyc == PW'(TICK_DIV - 1)) begin
            idle_cyc <= '0;
            idle_sec <= SW'(idle_sec + 1'b1);
        end else begin
            idle_cyc <= PW'(idle_cyc + 1'b1);
        end
    end

    assign timeout_hit = ~(|press) && (idle_cyc == PW'(TICK_DIV - 1))
                         && (idle_sec == SW'(TIMEOUT_S - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            sec_tick  <= 1'b0;
            load      <= 1'b0;
            ld_hour   <= '0;
            ld_min    <= '0;
            ld_sec    <= '0;
            blink     <= 1'b0;
            pre_cnt   <= '0;
            blink_cnt <= '0;
        end else begin
            sec_tick <= 1'b0;
            load     <= 1'b0;
            case (state)
                RUN: begin
                    blink     <= 1'b0;
                    blink_cnt <= '0;
                    if (mode_p) begin
                        state   <= SET_H;
                        ld_hour <= cur_hour;
                        ld_min  <= cur_min;
                        ld_sec  <= cur_sec;
                        pre_cnt <= '0;
                    end else begin
                        // sec_tick is high while pre_cnt sits at TICK_DIV-1
                        pre_cnt  <= (pre_cnt == PW'(TICK_DIV - 1)) ? '0 : PW'(pre_cnt + 1'b1);
                        sec_tick <= (pre_cnt == PW'(TICK_DIV - 2));
                    end
                end
                default: begin
                    pre_cnt <= '0;
                    if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                        blink_cnt <= '0;
                        blink     <= ~blink;
                    end else begin
                        blink_cnt <= BW'(blink_cnt + 1'b1);
                    end
                    if (mode_p) begin
                        case (state)
                            SET_H:   state <= SET_M;
                            SET_M:   state <= SET_S;
                            default: begin
                                state <= RUN;
                                load  <= 1'b1;
                                blink <= 1'b0;
                            end
                        endcase
                    end else if (timeout_hit) begin
                        state <= RUN;
                        blink <= 1'b0;
                    end else if (adj_p) begin
                        case (state)
                            SET_H:   ld_hour <= 5'(wrap_step({1'b0, ld_hour}, 6'd23, inc_p));
                            SET_M:   ld_min  <= wrap_step(ld_min, 6'd59, inc_p);
                            default: ld_sec  <= wrap_step(ld_sec, 6'd59, inc_p);
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: directed scenarios plus randomized button
// sequences scored against a field-level model of the set-mode rules.
module tb_clock_set_ctrl;

    localparam int unsigned TD = 4;
    localparam int unsigned BD = 3;
`ifdef CLOCK_SET_TIMEOUT_EN
    localparam int unsigned TO = 2;
`else
    localparam int unsigned TO = 30;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       btn_dec = 1'b0;
    logic [4:0] cur_hour = '0;
    logic [5:0] cur_min = '0;
    logic [5:0] cur_sec = '0;
    logic       sec_tick;
    logic       load;
    logic [4:0] ld_hour;
    logic [5:0] ld_min;
    logic [5:0] ld_sec;
    logic [1:0] field_sel;
    logic       blink;

    clock_set_ctrl #(.TICK_DIV(TD), .BLINK_DIV(BD), .TIMEOUT_S(TO)) dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
        .sec_tick(sec_tick), .load(load), .ld_hour(ld_hour), .ld_min(ld_min), .ld_sec(ld_sec),
        .field_sel(field_sel), .blink(blink)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: selected field (0 = run) and the edit copy of the time
    int m_field = 0;
    int m_h = 0, m_m = 0, m_s = 0;
    int exp_loads = 0;
    int e_h = 0, e_m = 0, e_s = 0;

    int load_cnt = 0;
    int cap_h = 0, cap_m = 0, cap_s = 0;

    always @(negedge clk) begin
        if (load === 1'b1) begin
            load_cnt = load_cnt + 1;
            cap_h = int'(ld_hour);
            cap_m = int'(ld_min);
            cap_s = int'(ld_sec);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic model_apply(input logic [2:0] mask);
        int d;
        if (mask[0]) begin
            if (m_field == 0) begin
                m_h = int'(cur_hour);
                m_m = int'(cur_min);
                m_s = int'(cur_sec);
                m_field = 1;
            end else if (m_field == 3) begin
                m_field = 0;
                exp_loads = exp_loads + 1;
                e_h = m_h; e_m = m_m; e_s = m_s;
            end else begin
                m_field = m_field + 1;
            end
        end else if ((mask[1] ^ mask[2]) && m_field != 0) begin
            d = mask[1] ? 1 : -1;
            case (m_field)
                1: m_h = (m_h + d + 24) % 24;
                2: m_m = (m_m + d + 60) % 60;
                default: m_s = (m_s + d + 60) % 60;
            endcase
        end
    endtask

    // mask = {dec, inc, mode}; button held for 'hold' clock edges
    task automatic press(input logic [2:0] mask, input int hold);
        @(negedge clk);
        {btn_dec, btn_inc, btn_mode} = mask;
        repeat (hold) @(negedge clk);
        {btn_dec, btn_inc, btn_mode} = 3'b000;
        repeat (3) @(negedge clk);
        model_apply(mask);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        {btn_dec, btn_inc, btn_mode} = 3'b000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_field = 0; m_h = 0; m_m = 0; m_s = 0;
    endtask

    task automatic test_reset();
        logic [20:0] outs;
        @(negedge clk);
        rst = 1'b1;
        #1;
        outs = {sec_tick, load, ld_hour, ld_min, ld_sec, field_sel, blink};
        checks++;
        if (outs !== 21'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h exp 0", outs);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 13; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (sec_tick !== ((k % TD) == TD - 1)) begin
                errors++;
                $display("FAIL reset_tick k=%0d: got %b exp %b", k, sec_tick, (k % TD) == TD - 1);
            end
            checks++;
            if ({load, field_sel, blink} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_run_outputs k=%0d: got %b exp 0000", k, {load, field_sel, blink});
            end
        end
    endtask

    task automatic test_set_hours();
        do_reset();
        cur_hour = 5'd15; cur_min = 6'd41; cur_sec = 6'd3;
        press(3'b001, 1);
        repeat (3) press(3'b010, $urandom_range(1, 2));
        checks++;
        if ({field_sel, ld_hour, ld_min, ld_sec} !== {2'd1, 5'd18, 6'd41, 6'd3}) begin
            errors++;
            $display("FAIL set_hours: got sel=%0d %0d:%0d:%0d exp sel=1 18:41:3",
                     field_sel, ld_hour, ld_min, ld_sec);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (sec_tick !== 1'b0) begin
                errors++;
                $display("FAIL set_tick_silent k=%0d: got %b exp 0", k, sec_tick);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        cur_hour = 5'd23; cur_min = 6'd0; cur_sec = 6'd59;
        press(3'b001, 1);
        press(3'b010, 2);
        checks++;
        if ({field_sel, ld_hour} !== {2'd1, 5'd0}) begin
            errors++;
            $display("FAIL wrap_hour: got sel=%0d h=%0d exp sel=1 h=0", field_sel, ld_hour);
        end
        press(3'b001, 1);
        press(3'b100, 1);
        checks++;
        if ({field_sel, ld_min} !== {2'd2, 6'd59}) begin
            errors++;
            $display("FAIL wrap_min: got sel=%0d m=%0d exp sel=2 m=59", field_sel, ld_min);
        end
        press(3'b001, 2);
        press(3'b010, 1);
        checks++;
        if ({field_sel, ld_hour, ld_min, ld_sec} !== {2'd3, 5'd0, 6'd59, 6'd0}) begin
            errors++;
            $display("FAIL wrap_sec: got sel=%0d %0d:%0d:%0d exp sel=3 0:59:0",
                     field_sel, ld_hour, ld_min, ld_sec);
        end
        press(3'b001, 1);
    endtask

    task automatic test_commit();
        int found;
        int n_load;
        do_reset();
        cur_hour = 5'd10; cur_min = 6'd20; cur_sec = 6'd30;
        press(3'b001, 1);
        press(3'b001, 1);
        press(3'b001, 1);
        press(3'b010, 1);
        checks++;
        if ({field_sel, ld_sec} !== {2'd3, 6'd31}) begin
            errors++;
            $display("FAIL commit_pre: got sel=%0d s=%0d exp sel=3 s=31", field_sel, ld_sec);
        end
        @(negedge clk);
        btn_mode = 1'b1;
        found = 0;
        for (int k = 0; k < 8 && found == 0; k++) begin
            @(negedge clk);
            if (load === 1'b1) found = 1;
        end
        checks++;
        if (found == 0) begin
            errors++;
            $display("FAIL commit_load_seen: got none exp one pulse within 8 cycles");
        end else begin
            exp_loads++;
            m_field = 0;
            e_h = 10; e_m = 20; e_s = 31;
            checks++;
            if ({ld_hour, ld_min, ld_sec, field_sel, sec_tick} !== {5'd10, 6'd20, 6'd31, 2'd0, 1'b0}) begin
                errors++;
                $display("FAIL commit_values: got %0d:%0d:%0d sel=%0d tick=%b exp 10:20:31 sel=0 tick=0",
                         ld_hour, ld_min, ld_sec, field_sel, sec_tick);
            end
            n_load = 0;
            for (int k = 1; k < 10; k++) begin
                @(negedge clk);
                if (k == 3) btn_mode = 1'b0;
                if (load === 1'b1) n_load++;
                checks++;
                if (sec_tick !== ((k % TD) == TD - 1)) begin
                    errors++;
                    $display("FAIL commit_tick k=%0d: got %b exp %b", k, sec_tick, (k % TD) == TD - 1);
                end
            end
            checks++;
            if (n_load != 0) begin
                errors++;
                $display("FAIL commit_single_load: got %0d extra pulses exp 0", n_load);
            end
        end
        btn_mode = 1'b0;
        cur_hour = 5'd1; cur_min = 6'd2; cur_sec = 6'd3;
        repeat (5) @(negedge clk);
        checks++;
        if ({field_sel, ld_hour, ld_min, ld_sec} !== {2'd0, 5'd10, 6'd20, 6'd31}) begin
            errors++;
            $display("FAIL run_hold: got sel=%0d %0d:%0d:%0d exp sel=0 10:20:31",
                     field_sel, ld_hour, ld_min, ld_sec);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        cur_hour = 5'd5; cur_min = 6'd6; cur_sec = 6'd7;
        press(3'b010, 1);
        checks++;
        if (field_sel !== 2'd0) begin
            errors++;
            $display("FAIL run_inc_ignored: got sel=%0d exp 0", field_sel);
        end
        press(3'b001, 1);
        press(3'b110, 1);
        checks++;
        if ({field_sel, ld_hour} !== {2'd1, 5'd5}) begin
            errors++;
            $display("FAIL inc_dec_same: got sel=%0d h=%0d exp sel=1 h=5", field_sel, ld_hour);
        end
        press(3'b011, 2);
        checks++;
        if ({field_sel, ld_hour, ld_min} !== {2'd2, 5'd5, 6'd6}) begin
            errors++;
            $display("FAIL mode_inc_same: got sel=%0d h=%0d m=%0d exp sel=2 h=5 m=6",
                     field_sel, ld_hour, ld_min);
        end
        press(3'b010, 4);
        checks++;
        if (ld_min !== 6'd7) begin
            errors++;
            $display("FAIL held_inc_once: got m=%0d exp 7", ld_min);
        end
    endtask

    task automatic test_blink();
        int found;
        do_reset();
        @(negedge clk);
        btn_mode = 1'b1;
        found = 0;
        for (int k = 0; k < 8 && found == 0; k++) begin
            @(negedge clk);
            if (field_sel === 2'd1) found = 1;
        end
        checks++;
        if (found == 0) begin
            errors++;
            $display("FAIL blink_entry: got sel=%0d exp 1 within 8 cycles", field_sel);
        end else begin
            for (int c = 0; c < 7; c++) begin
                if (c > 0) @(negedge clk);
                checks++;
                if ({field_sel, blink} !== {2'd1, 1'((c / BD) % 2)}) begin
                    errors++;
                    $display("FAIL blink c=%0d: got sel=%0d blink=%b exp sel=1 blink=%0d",
                             c, field_sel, blink, (c / BD) % 2);
                end
            end
        end
        btn_mode = 1'b0;
    endtask

    task automatic test_reset_mid_edit();
        int loads0;
        logic [20:0] outs;
        do_reset();
        cur_hour = 5'd9; cur_min = 6'd30; cur_sec = 6'd45;
        press(3'b001, 1);
        press(3'b001, 1);
        press(3'b010, 1);
        checks++;
        if ({field_sel, ld_min} !== {2'd2, 6'd31}) begin
            errors++;
            $display("FAIL mid_edit_pre: got sel=%0d m=%0d exp sel=2 m=31", field_sel, ld_min);
        end
        loads0 = load_cnt;
        @(negedge clk);
        rst = 1'b1;
        #1;
        outs = {sec_tick, load, ld_hour, ld_min, ld_sec, field_sel, blink};
        checks++;
        if (outs !== 21'd0) begin
            errors++;
            $display("FAIL mid_edit_reset: got %h exp 0", outs);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_field = 0; m_h = 0; m_m = 0; m_s = 0;
        repeat (10) @(negedge clk);
        checks++;
        if (load_cnt != loads0 || field_sel !== 2'd0) begin
            errors++;
            $display("FAIL mid_edit_no_load: got loads=%0d sel=%0d exp loads=%0d sel=0",
                     load_cnt, field_sel, loads0);
        end
    endtask

    task automatic test_timeout();
        int found;
        int c;
        int loads0;
        do_reset();
        loads0 = load_cnt;
        @(negedge clk);
        btn_mode = 1'b1;
        found = 0;
        for (int k = 0; k < 8 && found == 0; k++) begin
            @(negedge clk);
            if (field_sel === 2'd1) found = 1;
        end
        btn_mode = 1'b0;
        c = 0;
        while (field_sel === 2'd1 && c < 40) begin
            @(negedge clk);
            c++;
        end
        checks++;
`ifdef CLOCK_SET_TIMEOUT_EN
        if (found == 0 || c != int'(TD * TO)) begin
            errors++;
            $display("FAIL timeout_cycles: got %0d exp %0d", c, TD * TO);
        end
`else
        if (found == 0 || field_sel !== 2'd1) begin
            errors++;
            $display("FAIL set_persists: got sel=%0d after %0d cycles exp 1", field_sel, c);
        end
`endif
        repeat (3) @(negedge clk);
        checks++;
        if (load_cnt != loads0) begin
            errors++;
            $display("FAIL timeout_no_load: got loads=%0d exp %0d", load_cnt, loads0);
        end
    endtask

    task automatic test_random();
        logic [2:0] mask;
        int r;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            cur_hour = 5'($urandom_range(0, 23));
            cur_min  = 6'($urandom_range(0, 59));
            cur_sec  = 6'($urandom_range(0, 59));
            r = int'($urandom_range(0, 9));
            if (r < 4)       mask = 3'b001;
            else if (r < 6)  mask = 3'b010;
            else if (r < 8)  mask = 3'b100;
            else if (r == 8) mask = 3'b110;
            else             mask = 3'b011;
            press(mask, $urandom_range(1, 2));
            checks++;
            if ({field_sel, ld_hour, ld_min, ld_sec} !== {2'(m_field), 5'(m_h), 6'(m_m), 6'(m_s)}) begin
                errors++;
                $display("FAIL random i=%0d mask=%b: got sel=%0d %0d:%0d:%0d exp sel=%0d %0d:%0d:%0d",
                         i, mask, field_sel, ld_hour, ld_min, ld_sec, m_field, m_h, m_m, m_s);
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if (load_cnt != exp_loads || cap_h != e_h || cap_m != e_m || cap_s != e_s) begin
            errors++;
            $display("FAIL load_scoreboard: got n=%0d last=%0d:%0d:%0d exp n=%0d last=%0d:%0d:%0d",
                     load_cnt, cap_h, cap_m, cap_s, exp_loads, e_h, e_m, e_s);
        end
    endtask

    initial begin
        test_reset();
        test_set_hours();
        test_wrap();
        test_commit();
        test_simultaneous();
        test_blink();
        test_reset_mid_edit();
        test_timeout();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
